// File: rtl/asrv32_lsu_master.sv
// asrv32_lsu_master: data-port bus initiator (stb/ack) with byte-lane steering and load extension.
// Defining ASRV32_LSU_TIMEOUT_EN adds an ACK_TIMEOUT-cycle ack watchdog that ends the access with o_bus_err.
module asrv32_lsu_master #(
    parameter int ACK_TIMEOUT = 16
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req,
    input  logic        i_we,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic        o_busy,
    output logic        o_done,
    output logic [31:0] o_rdata,
    output logic        o_misaligned,
    output logic        o_bus_err,
    output logic        o_stb,
    output logic        o_wr_en,
    output logic [31:0] o_addr,
    output logic [31:0] o_wdata,
    output logic [3:0]  o_wr_mask,
    input  logic        i_ack,
    input  logic [31:0] i_rdata
);

    typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;

    state_t      state;
    logic [2:0]  f3_q;
    logic [1:0]  off_q;
    logic        we_q;
    logic        mis_q;
    logic [31:0] res_q;

`ifdef ASRV32_LSU_TIMEOUT_EN
    localparam int CNT_W = $clog2(ACK_TIMEOUT);
    logic [CNT_W-1:0] cnt_q;
    logic             err_q;
`else
    assign o_bus_err = 1'b0;
`endif

    if (ACK_TIMEOUT < 2) begin : g_bad_timeout
        $error("ACK_TIMEOUT must be at least 2");
    end

    function automatic logic is_legal(input logic [2:0] f3);
        return (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
               (f3 == 3'b100) || (f3 == 3'b101);
    endfunction

    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
        case (f3[1:0])
            2'b01:   return off[0];
            2'b10:   return off != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] lane_mask(input logic [2:0] f3, input logic [1:0] off);
        case (f3[1:0])
            2'b00:   return 4'b0001 << off;
            2'b01:   return 4'b0011 << off;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] lane_data(input logic [2:0] f3, input logic [31:0] d);
        case (f3[1:0])
            2'b00:   return {4{d[7:0]}};
            2'b01:   return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    // Halfwords are always 2-byte aligned here, so only off[1] selects their lane.
    function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] off,
                                                input logic [31:0] word);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        logic [31:0]        r;
        b = 8'(word >> {off, 3'b000});
        h = 16'(word >> {off[1], 4'b0000});
        case (f3)
            3'b000:  r = 32'(b);
            3'b001:  r = 32'(h);
            3'b100:  r = {24'd0, b};
            3'b101:  r = {16'd0, h};
            default: r = word;
        endcase
        return r;
    endfunction

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state        <= IDLE;
            o_busy       <= 1'b0;
            o_done       <= 1'b0;
            o_rdata      <= '0;
            o_misaligned <= 1'b0;
            o_stb        <= 1'b0;
            o_wr_en      <= 1'b0;
            o_addr       <= '0;
            o_wdata      <= '0;
            o_wr_mask    <= '0;
`ifdef ASRV32_LSU_TIMEOUT_EN
            cnt_q        <= '0;
            err_q        <= 1'b0;
            o_bus_err    <= 1'b0;
`endif
        end else begin
            o_done       <= 1'b0;
            o_misaligned <= 1'b0;
`ifdef ASRV32_LSU_TIMEOUT_EN
            o_bus_err    <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    // A request coinciding with the completion pulse is dropped; the core re-requests.
                    if (i_req && !o_done) begin
                        o_busy <= 1'b1;
                        f3_q   <= i_funct3;
                        off_q  <= i_addr[1:0];
                        we_q   <= i_we;
`ifdef ASRV32_LSU_TIMEOUT_EN
                        cnt_q  <= '0;
                        err_q  <= 1'b0;
`endif
                        if (!is_legal(i_funct3) || is_misaligned(i_funct3, i_addr[1:0])) begin
                            mis_q <= 1'b1;
                            res_q <= '0;
                            state <= DONE;
                        end else begin
                            mis_q     <= 1'b0;
                            o_stb     <= 1'b1;
                            o_wr_en   <= i_we;
                            o_addr    <= {i_addr[31:2], 2'b00};
                            o_wdata   <= lane_data(i_funct3, i_wdata);
                            o_wr_mask <= i_we ? lane_mask(i_funct3, i_addr[1:0]) : 4'b0000;
                            state     <= BUS;
                        end
                    end
                end
                BUS: begin
                    if (i_ack) begin
                        o_stb   <= 1'b0;
                        o_wr_en <= 1'b0;
                        res_q   <= we_q ? '0 : load_extend(f3_q, off_q, i_rdata);
                        state   <= DONE;
                    end
`ifdef ASRV32_LSU_TIMEOUT_EN
                    else if (cnt_q == CNT_W'(ACK_TIMEOUT - 1)) begin
                        o_stb   <= 1'b0;
                        o_wr_en <= 1'b0;
                        res_q   <= '0;
                        err_q   <= 1'b1;
                        state   <= DONE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
`endif
                end
                DONE: begin
                    o_done       <= 1'b1;
                    o_rdata      <= res_q;
                    o_misaligned <= mis_q;
`ifdef ASRV32_LSU_TIMEOUT_EN
                    o_bus_err    <= err_q;
`endif
                    o_busy       <= 1'b0;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_asrv32_lsu_master.sv
// Scoreboard bench for asrv32_lsu_master: random and directed loads/stores against an arithmetic reference model.
module tb_asrv32_lsu_master;

    localparam int TMO = 16;

    logic        i_clk = 1'b0;
    logic        i_rst, i_req, i_we, i_ack;
    logic [2:0]  i_funct3;
    logic [31:0] i_addr, i_wdata, i_rdata;
    logic        o_busy, o_done, o_misaligned, o_bus_err, o_stb, o_wr_en;
    logic [31:0] o_rdata, o_addr, o_wdata;
    logic [3:0]  o_wr_mask;

    asrv32_lsu_master #(.ACK_TIMEOUT(TMO)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_req(i_req), .i_we(i_we), .i_funct3(i_funct3),
        .i_addr(i_addr), .i_wdata(i_wdata), .o_busy(o_busy), .o_done(o_done),
        .o_rdata(o_rdata), .o_misaligned(o_misaligned), .o_bus_err(o_bus_err),
        .o_stb(o_stb), .o_wr_en(o_wr_en), .o_addr(o_addr), .o_wdata(o_wdata),
        .o_wr_mask(o_wr_mask), .i_ack(i_ack), .i_rdata(i_rdata)
    );

    always #5 i_clk = ~i_clk;

    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        mis;
        logic        err;
        int          cyc;
    } sb_t;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  mask;
        logic [31:0] wdata;
        logic        we;
        int          k;
        logic [31:0] word;
        logic        aborted;
    } bus_t;

    sb_t  sbq[$];
    bus_t busq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---- reference model: RV32I load/store semantics in plain arithmetic ----
    function automatic int sz_of(input logic [2:0] f3);
        case (f3)
            3'd0, 3'd4: return 1;
            3'd1, 3'd5: return 2;
            default:    return 4;
        endcase
    endfunction

    function automatic bit legal(input logic [2:0] f3);
        return f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr,
                                               input logic [31:0] word);
        int     sz, off;
        longint v, full;
        sz = sz_of(f3);
        off = int'(addr % 4);
        if (sz == 4) return word;
        full = longint'(1) << (8 * sz);
        v = (longint'({32'd0, word}) >> (8 * off)) % full;
        if ((f3 == 3'd0 || f3 == 3'd1) && v >= full / 2) v = v - full;
        return 32'(v);
    endfunction

    function automatic logic [3:0] model_mask(input bit we, input logic [2:0] f3,
                                              input logic [31:0] addr);
        logic [3:0] m;
        int         off, sz;
        m = '0;
        off = int'(addr % 4);
        sz = sz_of(f3);
        if (!we) return m;
        for (int i = 0; i < 4; i++)
            if (i >= off && i < off + sz) m[i] = 1'b1;
        return m;
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] d);
        logic [31:0] r;
        int          sz;
        sz = sz_of(f3);
        r = '0;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = d[8*(i % sz) +: 8];
        return r;
    endfunction

    // ---- stimulus helpers (called at #1 after a rising edge) ----
    task automatic wait_idle();
        for (int i = 0; i < 300; i++) begin
            if (!o_busy && !o_done) return;
            @(posedge i_clk); #1;
        end
        chk("wait_idle_timeout", 32'd1, 32'd0);
    endtask

    task automatic issue(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input int k, input logic [31:0] word,
                         input bit poke_busy);
        bit ok, err;
        int keff;
        wait_idle();
        i_req = 1'b1; i_we = we; i_funct3 = f3; i_addr = addr; i_wdata = wdata;
        ok = legal(f3) && (addr % sz_of(f3) == 0);
        if (!ok) begin
            sbq.push_back('{rdata: 32'd0, mis: 1'b1, err: 1'b0, cyc: cyc + 2});
        end else begin
            err = 1'b0;
            keff = k;
`ifdef ASRV32_LSU_TIMEOUT_EN
            err = (k >= TMO);
            if (err) keff = TMO - 1;
`endif
            sbq.push_back('{rdata: (we || err) ? 32'd0 : model_load(f3, addr, word),
                            mis: 1'b0, err: err, cyc: cyc + 3 + keff});
            busq.push_back('{addr: addr & ~32'd3, mask: model_mask(we, f3, addr),
                             wdata: model_wdata(f3, wdata), we: we, k: k, word: word,
                             aborted: 1'b0});
        end
        @(posedge i_clk); #1;
        i_req = 1'b0; i_we = $urandom_range(0, 1); i_funct3 = 3'($urandom);
        i_addr = $urandom; i_wdata = $urandom;
        if (poke_busy) begin
            i_req = 1'b1;
            @(posedge i_clk); #1;
            i_req = 1'b0;
        end
    endtask

    task automatic poke_done();
        for (int i = 0; i < 100; i++) begin
            @(negedge i_clk);
            if (o_done) break;
        end
        chk("poke_done_seen", o_done, 1'b1);
        i_req = 1'b1; i_we = 1'b0; i_funct3 = 3'd2; i_addr = 32'h300;
        @(posedge i_clk); #1;
        i_req = 1'b0;
    endtask

    // ---- bus responder: acks after k waits and checks bus outputs every stb cycle ----
    initial begin
        bus_t cur;
        bit   in_txn;
        int   ncyc, exp_cyc;
        in_txn = 0; ncyc = 0;
        cur = '{addr: 0, mask: 0, wdata: 0, we: 0, k: 0, word: 0, aborted: 1};
        i_ack = 1'b0; i_rdata = '0;
        forever begin
            @(negedge i_clk);
            if (o_stb) begin
                if (!in_txn) begin
                    if (busq.size() == 0) begin
                        chk("unexpected_stb", 32'd1, 32'd0);
                        cur = '{addr: 0, mask: 0, wdata: 0, we: 0, k: 0, word: 0, aborted: 1};
                    end else begin
                        cur = busq.pop_front();
                    end
                    in_txn = 1; ncyc = 0;
                end
                ncyc++;
                if (!cur.aborted || busq.size() == 0) begin
                    chk("bus_addr", o_addr, cur.addr);
                    chk("bus_mask", {28'd0, o_wr_mask}, {28'd0, cur.mask});
                    chk("bus_we", {31'd0, o_wr_en}, {31'd0, cur.we});
                    chk("busy_in_bus", {31'd0, o_busy}, 32'd1);
                    if (cur.we) chk("bus_wdata", o_wdata, cur.wdata);
                end
                if (ncyc == cur.k + 1) begin
                    i_ack = 1'b1; i_rdata = cur.word;
                end else begin
                    i_ack = 1'b0; i_rdata = $urandom;
                end
            end else begin
                if (in_txn) begin
                    in_txn = 0;
                    exp_cyc = cur.k + 1;
`ifdef ASRV32_LSU_TIMEOUT_EN
                    if (cur.k >= TMO) exp_cyc = TMO;
`endif
                    if (!cur.aborted) chk("stb_cycles", ncyc, exp_cyc);
                end
                i_ack = 1'($urandom_range(0, 1));
                i_rdata = $urandom;
            end
        end
    end

    // ---- monitor: pops the scoreboard on every completion pulse ----
    initial begin
        sb_t e;
        forever begin
            @(negedge i_clk);
            if (o_done) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = sbq.pop_front();
                    chk("rdata", o_rdata, e.rdata);
                    chk("misaligned", {31'd0, o_misaligned}, {31'd0, e.mis});
                    chk("bus_err", {31'd0, o_bus_err}, {31'd0, e.err});
                    chk("done_cycle", cyc, e.cyc);
                    chk("flags_exclusive", {31'd0, o_misaligned & o_bus_err}, 32'd0);
                    chk("busy_at_done", {31'd0, o_busy}, 32'd0);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          k;
        logic [2:0]  f3;
        logic [2:0]  legal_f3[5];
        legal_f3 = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        i_rst = 1'b1; i_req = 1'b0; i_we = 1'b0; i_funct3 = '0; i_addr = '0; i_wdata = '0;
        repeat (3) @(posedge i_clk);
        #1;
        chk("reset_ctrl", {25'd0, o_busy, o_done, o_stb, o_wr_en, o_misaligned, o_bus_err, 1'b0},
            32'd0);
        chk("reset_mask", {28'd0, o_wr_mask}, 32'd0);
        chk("reset_rdata", o_rdata, 32'd0);
        chk("reset_addr", o_addr, 32'd0);
        chk("reset_wdata", o_wdata, 32'd0);
        i_rst = 1'b0;

        issue(1'b0, 3'b010, 32'h0000_0104, 32'h0, 0, 32'hDEAD_BEEF, 1'b0);
        issue(1'b0, 3'b000, 32'h0000_0103, 32'h0, 1, 32'h80AA_5511, 1'b0);
        issue(1'b0, 3'b100, 32'h0000_0103, 32'h0, 0, 32'h80AA_5511, 1'b0);
        issue(1'b0, 3'b101, 32'h0000_0102, 32'h0, 2, 32'h80AA_5511, 1'b0);
        issue(1'b0, 3'b001, 32'h0000_0102, 32'h0, 0, 32'h80AA_5511, 1'b0);
        issue(1'b1, 3'b000, 32'h0000_0101, 32'h0000_00A5, 0, 32'h1111_1111, 1'b0);
        issue(1'b1, 3'b001, 32'h0000_0102, 32'h0000_1234, 1, 32'h2222_2222, 1'b0);
        issue(1'b0, 3'b010, 32'h0000_0102, 32'h0, 0, 32'h0, 1'b0);
        issue(1'b1, 3'b001, 32'h0000_0101, 32'h0000_1234, 0, 32'h0, 1'b0);
        issue(1'b0, 3'b011, 32'h0000_0100, 32'h0, 0, 32'h0, 1'b0);
        issue(1'b0, 3'b010, 32'h0000_0200, 32'h0, 4, 32'hCAFE_F00D, 1'b1);
        issue(1'b1, 3'b010, 32'h0000_0208, 32'h0BAD_CAFE, 2, 32'h0, 1'b0);
        poke_done();
`ifdef ASRV32_LSU_TIMEOUT_EN
        issue(1'b0, 3'b010, 32'h0000_0400, 32'h0, 1000, 32'h1234_5678, 1'b0);
        issue(1'b0, 3'b010, 32'h0000_0404, 32'h0, TMO - 1, 32'h8765_4321, 1'b0);
`endif

        // reset while the strobe is up: no completion, next access is clean
        wait_idle();
        busq.push_back('{addr: 32'h500, mask: 4'b0, wdata: 0, we: 0, k: 1000, word: 0, aborted: 1});
        i_req = 1'b1; i_we = 1'b0; i_funct3 = 3'd2; i_addr = 32'h500;
        @(posedge i_clk); #1;
        i_req = 1'b0;
        chk("stb_before_rst", {31'd0, o_stb}, 32'd1);
        i_rst = 1'b1;
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        chk("stb_after_rst", {31'd0, o_stb}, 32'd0);
        chk("busy_after_rst", {31'd0, o_busy}, 32'd0);
        repeat (4) @(posedge i_clk);
        #1;
        issue(1'b0, 3'b000, 32'h0000_0501, 32'h0, 1, 32'h0000_7F00, 1'b0);

        for (int n = 0; n < 150; n++) begin
            f3 = ($urandom_range(0, 7) == 0) ? 3'($urandom) : legal_f3[$urandom_range(0, 4)];
            k = $urandom_range(0, 6);
`ifdef ASRV32_LSU_TIMEOUT_EN
            if ($urandom_range(0, 9) == 0) k = TMO + 4;
`endif
            issue(1'($urandom_range(0, 1)), f3, $urandom, $urandom, k, $urandom,
                  1'($urandom_range(0, 3) == 0));
        end

        wait_idle();
        repeat (5) @(posedge i_clk);
        #1;
        chk("sb_drained", sbq.size(), 32'd0);
        chk("bus_drained", busq.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/asrv32_lsu_master.md
Name: asrv32_lsu_master

Overview:
- Bus initiator for the data port of main memory; drives the stb/ack handshake that the memory answers.
- Sits between the core's load/store stage and the memory data interface.
- Per request: word-aligns the address, builds the byte write mask and replicated store data, checks alignment, waits for ack, then returns load data extracted by lane and sign/zero-extended.

Parameters:
- ACK_TIMEOUT, 16, cycles o_stb may stay high without i_ack before the transaction aborts with a bus error (used only when ASRV32_LSU_TIMEOUT_EN is defined).

Ports:
- i_clk  in  1  system clock, rising edge
- i_rst  in  1  synchronous active-high reset
- i_req  in  1  core request, sampled only in IDLE
- i_we  in  1  1=store, 0=load
- i_funct3  in  3  RV32I size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- i_addr  in  32  byte address
- i_wdata  in  32  store data, LSB-aligned
- o_busy  out  1  high in every state except IDLE
- o_done  out  1  one-cycle completion pulse
- o_rdata  out  32  extended load result, valid with o_done
- o_misaligned  out  1  valid with o_done; misaligned access, no bus cycle issued
- o_bus_err  out  1  valid with o_done; ack timeout
- o_stb  out  1  bus request, held until ack
- o_wr_en  out  1  bus write enable, qualified by o_stb
- o_addr  out  32  {i_addr[31:2],2'b00}
- o_wdata  out  32  replicated store data
- o_wr_mask  out  4  byte-lane mask
- i_ack  in  1  responder ack
- i_rdata  in  32  responder read word, valid with i_ack

Behaviour:
- Reset: state IDLE; all outputs 0; timeout counter 0. Reset mid-transaction drops o_stb at that edge and suppresses o_done.
- All outputs are registered.
- FSM states: IDLE, BUS, DONE.
- IDLE, i_req=1, funct3 illegal (011,110,111) or misaligned (H/HU with addr[0]=1; W with addr[1:0]!=0):
  - go to DONE.
  - o_misaligned=1, o_stb stays 0.
- IDLE, i_req=1, legal and aligned:
  - latch request; go to BUS.
  - o_stb=1, o_wr_en=i_we.
  - o_wr_mask: B = 0001<<addr[1:0]; H = 0011<<addr[1:0]; W = 1111; loads = 0000.
  - o_wdata: B = {4{wdata[7:0]}}; H = {2{wdata[15:0]}}; W = wdata.
- BUS:
  - o_stb and bus outputs held stable until i_ack=1 is sampled.
  - On ack: go to DONE, o_stb=0, capture load lane from i_rdata.
  - Lane select: B by addr[1:0], H by addr[1].
  - Extension: B/H sign-extend; BU/HU zero-extend; W unchanged.
  - Stores: o_rdata=0.
- DONE:
  - o_done=1 for exactly one cycle with the result flags, then IDLE.
  - o_rdata holds its value until the next o_done.
- Latency:
  - i_req at edge N → o_stb high after N.
  - Ack first sampled at edge N+1+k → o_done high after edge N+2+k.
  - Minimum request-to-done: 2 cycles.
  - Misaligned request-to-done: 1 cycle.
- Boundaries:
  - i_req while o_busy is ignored and not queued.
  - i_ack in IDLE or DONE is ignored.
  - A new i_req in the same cycle o_done is high is ignored; the core re-requests from IDLE.
  - o_misaligned and o_bus_err are never both 1.

Optional Feature:
- Macro: ASRV32_LSU_TIMEOUT_EN.
- Defined:
  - Counter clears on entry to BUS and increments every BUS cycle without ack.
  - When it reaches ACK_TIMEOUT, drop o_stb, go to DONE with o_bus_err=1 and o_rdata=0.
  - Ack in the same cycle the count reaches ACK_TIMEOUT wins: normal completion.
- Undefined:
  - No counter; BUS waits indefinitely.
  - o_bus_err tied to 0.

Test Plan:
- LW addr 0x0000_0104, ack after 1 cycle, i_rdata 0xDEAD_BEEF → o_stb 1 cycle, o_addr 0x104, mask 0000, o_done with o_rdata 0xDEAD_BEEF.
- LB addr 0x103, i_rdata 0x80AA_5511 → o_rdata 0xFFFF_FF80. LBU same → 0x0000_0080. LHU addr 0x102 → 0x0000_80AA.
- SB addr 0x101, wdata 0x0000_00A5 → o_wr_en 1, mask 0010, o_wdata 0xA5A5_A5A5. SH addr 0x102, wdata 0x1234 → mask 1100, o_wdata 0x1234_1234.
- LW addr 0x102 → o_stb never rises, o_done+o_misaligned one cycle after request. SH addr 0x101 → same.
- Ack withheld 4 cycles → o_stb, o_addr and mask stable 5 cycles, o_busy high, second i_req during BUS ignored. With ASRV32_LSU_TIMEOUT_EN and ACK_TIMEOUT=16, no ack → o_bus_err pulse after 16 BUS cycles.
- Assert i_rst while o_stb=1 → o_stb 0 after that edge, no o_done; a request after reset completes normally.
